// File: rtl/avalon_read_master.sv
// avalon_read_master: issues single-word Avalon-MM pipelined reads into a show-ahead FIFO
module avalon_read_master #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTHLOG2   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_output_data,
  output logic                       user_data_available,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam logic [ADDRESSWIDTH-1:0] STRIDE   = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ~(STRIDE - 1'b1);
  localparam int CW = FIFODEPTHLOG2 + 1;
  state_t state, state_d;
  logic [ADDRESSWIDTH-1:0] address, address_d, remaining, remaining_d, masked_len;
  logic fixed, fixed_d;
  logic [CW-1:0] outstanding, outstanding_d, wr_ptr, rd_ptr, used;
  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic accept, push, pop, credit;
  assign masked_len = control_read_length & LEN_MASK;
  assign used = wr_ptr - rd_ptr;
  // Reads in flight count against FIFO space, so returned beats always fit.
  assign credit = (CW+1)'(used) + (CW+1)'(outstanding) < (CW+1)'(FIFODEPTH);
  assign master_read = (state == ISSUE) && (remaining != '0) && credit;
  assign master_address = address;
  assign master_byteenable = '1;
  assign control_done = (state == IDLE);
  assign accept = master_read & ~master_waitrequest;
  assign push = master_readdatavalid & ((outstanding != '0) | accept);
  assign pop = user_read_buffer & (used != '0);
  assign user_data_available = (used != '0);
  assign user_buffer_output_data = mem[rd_ptr[FIFODEPTHLOG2-1:0]];
  always_comb begin
    state_d = state;
    address_d = address;
    remaining_d = remaining;
    fixed_d = fixed;
    outstanding_d = outstanding + CW'(accept) - CW'(push);
    if (state == IDLE && control_go) begin
      address_d = control_read_base;
      remaining_d = masked_len;
      fixed_d = control_fixed_location;
      state_d = (masked_len != '0) ? ISSUE : IDLE;
    end
    if (accept) begin
      remaining_d = remaining - STRIDE;
      address_d = fixed ? address : address + STRIDE;
      state_d = (remaining == STRIDE) ? DRAIN : ISSUE;
    end
    if (state == DRAIN && outstanding == '0) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      address <= '0;
      remaining <= '0;
      fixed <= 1'b0;
      outstanding <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_d;
      address <= address_d;
      remaining <= remaining_d;
      fixed <= fixed_d;
      outstanding <= outstanding_d;
      wr_ptr <= wr_ptr + CW'(push);
      rd_ptr <= rd_ptr + CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr[FIFODEPTHLOG2-1:0]] <= master_readdata;
endmodule

// File: tb/tb_avalon_read_master.sv
// tb_avalon_read_master: directed tests with a latency-2 Avalon slave model
module tb_avalon_read_master;
  localparam int AW = 28, DW = 32, BEW = 4;
  logic clk = 0, reset = 0;
  logic control_fixed_location = 0, control_go = 0, control_done;
  logic [AW-1:0] control_read_base = '0, control_read_length = '0, master_address;
  logic user_read_buffer = 0, user_data_available, master_read;
  logic [DW-1:0] user_buffer_output_data, master_readdata = '0, data_base = '0;
  logic [BEW-1:0] master_byteenable;
  logic master_readdatavalid = 0, master_waitrequest = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, stall_idx = -1, stall_left = 0;
  logic [AW-1:0] addr_q[$], stall_q[$];
  logic [DW-1:0] pend_d[$];
  int pend_t[$];
  avalon_read_master dut (
    .clk(clk), .reset(reset),
    .control_fixed_location(control_fixed_location), .control_read_base(control_read_base),
    .control_read_length(control_read_length), .control_go(control_go), .control_done(control_done),
    .user_read_buffer(user_read_buffer), .user_buffer_output_data(user_buffer_output_data),
    .user_data_available(user_data_available), .master_address(master_address),
    .master_read(master_read), .master_byteenable(master_byteenable),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest)
  );
  always #5 clk = ~clk;
  // Slave: observe at negedge, answer each accepted read two edges later.
  initial forever begin
    @(negedge clk);
    if (master_read && master_waitrequest) stall_q.push_back(master_address);
    if (master_read && !master_waitrequest) begin
      addr_q.push_back(master_address);
      pend_d.push_back(data_base + DW'(n_acc));
      pend_t.push_back(cyc + 2);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    master_waitrequest = (n_acc == stall_idx) && (stall_q.size() < stall_left);
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      master_readdatavalid = 1;
      master_readdata = pend_d.pop_front();
      void'(pend_t.pop_front());
    end else begin
      master_readdatavalid = 0;
      master_readdata = '0;
    end
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear(logic [DW-1:0] db);
    data_base = db;
    n_acc = 0;
    addr_q.delete();
    stall_q.delete();
  endtask
  task automatic start(logic [AW-1:0] b, logic [AW-1:0] l, logic f);
    control_read_base = b;
    control_read_length = l;
    control_fixed_location = f;
    control_go = 1;
    step();
    control_go = 0;
  endtask
  task automatic wait_done(string tag);
    int i = 0;
    while (!control_done && i < 2000) begin
      step();
      i++;
    end
    chk(tag, control_done, 1);
  endtask
  task automatic pop_chk(string tag, logic [DW-1:0] exp);
    int i = 0;
    while (!user_data_available && i < 50) begin
      step();
      i++;
    end
    chk(tag, {user_data_available, user_buffer_output_data}, {1'b1, exp});
    user_read_buffer = 1;
    step();
    user_read_buffer = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_read", master_read, 0);
    chk("rst_addr", master_address, 0);
    chk("rst_done", control_done, 1);
    chk("rst_avail", user_data_available, 0);
    step(2);
    reset = 1;
    step(2);
    // single word read
    clear(32'hFEEDFEED);
    start(28'h100, 28'd4, 0);
    chk("t1_done_low", control_done, 0);
    wait_done("t1_done");
    chk("t1_nacc", n_acc, 1);
    chk("t1_addr", addr_q.size() > 0 ? addr_q[0] : '1, 28'h100);
    chk("t1_be", master_byteenable, 4'hF);
    chk("t1_avail", user_data_available, 1);
    pop_chk("t1_head", 32'hFEEDFEED);
    chk("t1_empty", user_data_available, 0);
    // four words, second read stalled three cycles
    clear(32'h2000_0000);
    stall_idx = 1;
    stall_left = 3;
    start(28'h100, 28'd16, 0);
    wait_done("t2_done");
    stall_idx = -1;
    chk("t2_nacc", n_acc, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), i < addr_q.size() ? addr_q[i] : '1, 28'h100 + AW'(4 * i));
    chk("t2_stalls", stall_q.size(), 3);
    foreach (stall_q[i]) chk($sformatf("t2_hold%0d", i), stall_q[i], 28'h104);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("t2_data%0d", i), 32'h2000_0000 + DW'(i));
    // 64 words against a 32-deep FIFO with no pops
    clear(32'h3000_0000);
    start(28'h1000, 28'd256, 0);
    step(60);
    chk("t3_credit", n_acc, 32);
    chk("t3_read_low", master_read, 0);
    chk("t3_busy", control_done, 0);
    pop_chk("t3_data0", 32'h3000_0000);
    step(6);
    chk("t3_one_more", n_acc, 33);
    for (int i = 1; i < 64; i++) pop_chk($sformatf("t3_data%0d", i), 32'h3000_0000 + DW'(i));
    wait_done("t3_done");
    chk("t3_nacc", n_acc, 64);
    chk("t3_last_addr", addr_q.size() == 64 ? addr_q[63] : '1, 28'h10FC);
    chk("t3_empty", user_data_available, 0);
    // fixed address, go during transfer ignored
    clear(32'h4000_0000);
    start(28'h100, 28'd12, 1);
    step();
    start(28'h500, 28'd4, 0);
    wait_done("t4_done");
    step(5);
    chk("t4_nacc", n_acc, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_addr%0d", i), i < addr_q.size() ? addr_q[i] : '1, 28'h100);
    for (int i = 0; i < 3; i++) pop_chk($sformatf("t4_data%0d", i), 32'h4000_0000 + DW'(i));
    chk("t4_empty", user_data_available, 0);
    // zero and truncated lengths
    clear(32'h5000_0000);
    start(28'h200, 28'd0, 0);
    chk("t5_len0_done", control_done, 1);
    step(5);
    chk("t5_len0_nacc", n_acc, 0);
    chk("t5_len0_read", master_read, 0);
    start(28'h200, 28'd6, 0);
    wait_done("t5_done");
    chk("t5_nacc", n_acc, 1);
    chk("t5_addr", addr_q.size() > 0 ? addr_q[0] : '1, 28'h200);
    pop_chk("t5_data", 32'h5000_0000);
    chk("t5_empty", user_data_available, 0);
    // reset with two reads in flight
    clear(32'h6000_0000);
    start(28'h300, 28'd64, 0);
    step(2);
    chk("t6_inflight", n_acc, 2);
    reset = 0;
    #1;
    chk("t6_rst_read", master_read, 0);
    chk("t6_rst_addr", master_address, 0);
    chk("t6_rst_done", control_done, 1);
    chk("t6_rst_avail", user_data_available, 0);
    step();
    reset = 1;
    step(4);
    chk("t6_late_avail", user_data_available, 0);
    chk("t6_late_done", control_done, 1);
    chk("t6_late_read", master_read, 0);
    chk("t6_nacc", n_acc, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
